// File: rtl/reg_file.sv
// Two-read / one-write architectural register file with optional hardwired-zero entry 0.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  wr_ok;

    // Writes aimed at a hardwired-zero entry 0 are dropped here, so the array never holds them.
    assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    always_comb begin
        mem_d = mem_q;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
        end else if (wr_ok) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        rd_data1 = mem_q[rd_addr1];
`ifdef REG_FILE_BYPASS_EN
        if (!rst && wr_ok && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
        end
`endif
        if ((ZERO_REG != 0) && (rd_addr1 == '0)) begin
            rd_data1 = '0;
        end
    end

    always_comb begin
        rd_data2 = mem_q[rd_addr2];
`ifdef REG_FILE_BYPASS_EN
        if (!rst && wr_ok && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
        end
`endif
        if ((ZERO_REG != 0) && (rd_addr2 == '0)) begin
            rd_data2 = '0;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: one ZERO_REG=1 and one ZERO_REG=0 instance share all inputs.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  rd_addr1 = '0;
    logic [4:0]  rd_addr2 = '0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic        chk_vld = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] b1;
        logic [31:0] b2;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(a_rd1), .rd_data2(a_rd2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(b_rd1), .rd_data2(b_rd2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic cmp(input string name, input string port, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got 0x%08h expected 0x%08h", name, port, act, exp);
        end
    endtask

    // Monitor: compares the outputs presented in each cycle flagged by the stimulus.
    always @(negedge clk) begin
        if (chk_vld) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got no expected entry, required one");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                cmp(e.name, "a_rd1", a_rd1, e.a1);
                cmp(e.name, "a_rd2", a_rd2, e.a2);
                cmp(e.name, "b_rd1", b_rd1, e.b1);
                cmp(e.name, "b_rd2", b_rd2, e.b2);
            end
        end
    end

    task automatic cyc(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra1, input logic [4:0] ra2, input logic chk,
                       input logic [31:0] ea1, input logic [31:0] ea2,
                       input logic [31:0] eb1, input logic [31:0] eb2, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst      = r;
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        rd_addr1 = ra1;
        rd_addr2 = ra2;
        chk_vld  = chk;
        if (chk) begin
            e.a1 = ea1; e.a2 = ea2; e.b1 = eb1; e.b2 = eb2; e.name = name;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        logic [31:0] v1, v2, coll;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
        cyc(0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, "reset_state");
        cyc(0, 1, 5, 32'hDEADBEEF, 1, 2, 1, 0, 0, 0, 0, "write_r5_other_ports");
        // Reads during the reset cycle still show stored contents.
        cyc(1, 0, 0, 0, 5, 5, 1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, "r5_during_rst");
        cyc(0, 0, 0, 0, 5, 5, 1, 0, 0, 0, 0, "r5_after_rst");
        cyc(0, 1, 3, 32'h12345678, 1, 1, 0, 0, 0, 0, 0, "");
        cyc(0, 1, 7, 32'hA5A5A5A5, 3, 3, 1, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, "read_r3");
        cyc(0, 0, 0, 0, 3, 7, 1, 32'h12345678, 32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5, "read_r3_r7");
        cyc(0, 1, 0, 32'hFFFFFFFF, 3, 7, 0, 0, 0, 0, 0, "");
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, "zero_reg");
        // No forwarding while rst is high, even with a matching write.
        cyc(1, 1, 9, 32'h55, 9, 0, 1, 0, 0, 0, 32'hFFFFFFFF, "rst_write_cycle");
        cyc(0, 0, 0, 0, 9, 0, 1, 0, 0, 0, 0, "rst_priority");
        cyc(0, 1, 4, 32'h11, 1, 1, 0, 0, 0, 0, 0, "");
        coll = BYP ? 32'h22 : 32'h11;
        cyc(0, 1, 4, 32'h22, 4, 4, 1, coll, coll, coll, coll, "collision_same_cycle");
        cyc(0, 0, 0, 0, 4, 4, 1, 32'h22, 32'h22, 32'h22, 32'h22, "collision_next_cycle");
        coll = BYP ? 32'h77 : 32'h0;
        cyc(0, 1, 0, 32'h77, 0, 0, 1, 0, 0, coll, coll, "zero_reg_collision");
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h77, 32'h77, "zero_reg_after");
        for (int i = 0; i < 32; i++) begin
            v1 = 32'(i) * 32'h01010101;
            cyc(0, 1, 5'(i), v1, 0, 0, 0, 0, 0, 0, 0, "");
        end
        for (int i = 0; i < 32; i++) begin
            v1 = 32'(i) * 32'h01010101;
            v2 = 32'(31 - i) * 32'h01010101;
            cyc(0, 0, 0, 0, 5'(i), 5'(31 - i), 1, (i == 0) ? 32'h0 : v1, (i == 31) ? 32'h0 : v2,
                v1, v2, $sformatf("sweep_%0d", i));
        end
        cyc(0, 0, 3, 32'hDEADDEAD, 1, 2, 0, 0, 0, 0, 0, "");
        cyc(0, 0, 0, 0, 3, 3, 1, 32'h03030303, 32'h03030303, 32'h03030303, 32'h03030303, "wr_en_low");
        @(negedge clk);
        #1;
        chk_vld = 1'b0;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: got %0d pending entries, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
